clause_dispatcher: RTL and testbench

Clause dispatcher: a buffered, parametrised round-robin distributor that sits between the clause loader and the BCP engine array. It accepts up to `IN_WIDTH` clauses per cycle into an internal multi-write FIFO. It then hands up to `NUM_ENGINE` clauses per cycle to engines that are not full, rotating fairly across engines. Grants are registered, and the dispatcher supports flush for restarting on a new problem.

---
 rtl/clause_pkg.sv | 23 ++
 rtl/clause_fifo_mw.sv | 68 ++++++
 rtl/clause_dispatcher.sv | 146 ++++++++++++++
 tb/tb_clause_dispatcher.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clause_pkg.sv
// clause_pkg: constants and types shared by the clause dispatcher slice.
//   VAR_W / CLA_W : literal and clause widths for the default configuration
//                   (LIT_IDX_MAX = 1024, CLA_LENGTH = 3).
//   clause_t      : one packed clause at default width.
//   engine_idx_t  : engine index at the default engine count.
//   min_int       : small helper used for the acceptance clamp.
package clause_pkg;

  localparam int NUM_ENGINE_DEF  = 4;
  localparam int CLA_LENGTH_DEF  = 3;
  localparam int LIT_IDX_MAX_DEF = 1024;

  localparam int VAR_W = $clog2(LIT_IDX_MAX_DEF) + 1;
  localparam int CLA_W = CLA_LENGTH_DEF * VAR_W;

  typedef logic [CLA_W-1:0] clause_t;
  typedef logic [$clog2(NUM_ENGINE_DEF)-1:0] engine_idx_t;

  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/clause_fifo_mw.sv
// clause_fifo_mw: circular buffer accepting up to N_WR writes and N_RD reads
// per cycle. The first N_RD entries from head are presented combinationally.
// Ports:
//   clock, reset   : clock, synchronous active-high reset
//   flush          : empties the buffer (pointers and count to zero)
//   push_cnt       : number of wr_data entries to store this cycle (from index 0)
//   wr_data        : write data, packed from index 0
//   pop_cnt        : number of head entries consumed this cycle
//   head_data      : head, head+1, ... head+N_RD-1 entries
//   count          : registered occupancy
// The caller guarantees push_cnt fits the free space and pop_cnt <= count.
module clause_fifo_mw
  import clause_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = 33,
  parameter int N_WR  = 4,
  parameter int N_RD  = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1,
  localparam int WCW  = $clog2(N_WR) + 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [WCW-1:0]           push_cnt,
  input  logic [N_WR-1:0][W-1:0]   wr_data,
  input  logic [CW-1:0]            pop_cnt,
  output logic [N_RD-1:0][W-1:0]   head_data,
  output logic [CW-1:0]            count
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;

  // Storage has no reset; only entries below count are ever read out.
  // Pointer sums are PW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clock) begin
    if (!reset && !flush) begin
      for (int i = 0; i < N_WR; i++) begin
        if (i < int'(push_cnt)) begin
          mem[tail + PW'(i)] <= wr_data[i];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(pop_cnt);
      tail  <= tail + PW'(push_cnt);
      count <= count + CW'(push_cnt) - pop_cnt;
    end
  end

  always_comb begin
    head_data = '0;
    for (int j = 0; j < N_RD; j++) begin
      head_data[j] = mem[head + PW'(j)];
    end
  end

endmodule

// File: rtl/clause_dispatcher.sv
// clause_dispatcher: buffered round-robin distributor from the clause loader
// to the BCP engine array.
// Ports:
//   clock, reset       : clock, synchronous active-high reset
//   start_in           : dispatch enable (pushes continue while low)
//   flush_in           : discard all buffered clauses
//   clause_in          : up to IN_WIDTH offered clauses, packed from index 0
//   clause_cnt_in      : number of valid offered clauses
//   full_in            : per-engine backpressure
//   clause_accept_out  : clauses taken this cycle (combinational)
//   clause_out         : registered clause per engine
//   grant_out          : registered valid per engine
//   fifo_count_out     : buffer occupancy
//   empty_out          : buffer empty
//   grant_cnt_out      : per-engine saturating grant totals, only when the
//                        macro CLA_DISPATCH_STATS_EN is defined
module clause_dispatcher
  import clause_pkg::*;
#(
  parameter int NUM_ENGINE  = 4,
  parameter int CLA_LENGTH  = 3,
  parameter int LIT_IDX_MAX = 1024,
  parameter int IN_WIDTH    = 4,
  parameter int FIFO_DEPTH  = 16,
  localparam int LIT_BITS    = $clog2(LIT_IDX_MAX) + 1,
  localparam int CLAUSE_BITS = CLA_LENGTH * LIT_BITS,
  localparam int ACW         = $clog2(IN_WIDTH) + 1,
  localparam int FCW         = $clog2(FIFO_DEPTH) + 1,
  localparam int EW          = $clog2(NUM_ENGINE)
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  start_in,
  input  logic                                  flush_in,
  input  logic [IN_WIDTH-1:0][CLAUSE_BITS-1:0]  clause_in,
  input  logic [ACW-1:0]                        clause_cnt_in,
  input  logic [NUM_ENGINE-1:0]                 full_in,
  output logic [ACW-1:0]                        clause_accept_out,
  output logic [NUM_ENGINE-1:0][CLAUSE_BITS-1:0] clause_out,
  output logic [NUM_ENGINE-1:0]                 grant_out,
  output logic [FCW-1:0]                        fifo_count_out,
  output logic                                  empty_out
`ifdef CLA_DISPATCH_STATS_EN
  ,
  output logic [NUM_ENGINE-1:0][31:0]           grant_cnt_out
`endif
);

  logic [NUM_ENGINE-1:0][CLAUSE_BITS-1:0] head_data;
  logic [FCW-1:0]                         fifo_count;
  logic [FCW-1:0]                         pop_cnt;
  logic [NUM_ENGINE-1:0]                  grant_next;
  logic [NUM_ENGINE-1:0][CLAUSE_BITS-1:0] clause_next;
  logic [EW-1:0]                          rr_ptr;
  logic [EW-1:0]                          rr_next;
  int                                     cnt_eff;
  int                                     room;
  int                                     pops;
  int                                     eng;

  clause_fifo_mw #(
    .DEPTH (FIFO_DEPTH),
    .W     (CLAUSE_BITS),
    .N_WR  (IN_WIDTH),
    .N_RD  (NUM_ENGINE)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush_in),
    .push_cnt  (clause_accept_out),
    .wr_data   (clause_in),
    .pop_cnt   (pop_cnt),
    .head_data (head_data),
    .count     (fifo_count)
  );

  // Free space comes from registered occupancy only, so full_in never
  // reaches this path and same-cycle pops do not make room.
  always_comb begin
    cnt_eff = min_int(int'(clause_cnt_in), IN_WIDTH);
    room    = FIFO_DEPTH - int'(fifo_count);
    if (reset || flush_in) begin
      clause_accept_out = '0;
    end else begin
      clause_accept_out = ACW'(min_int(cnt_eff, room));
    end
  end

  // Walk engines from rr_ptr; each non-full engine takes the next head entry
  // until the buffered count is exhausted. The pointer moves just past the
  // last engine served, so an idle cycle leaves it where it was.
  always_comb begin
    grant_next  = '0;
    clause_next = '0;
    rr_next     = rr_ptr;
    pops        = 0;
    eng         = 0;
    if (start_in && !flush_in) begin
      for (int s = 0; s < NUM_ENGINE; s++) begin
        eng = int'(rr_ptr) + s;
        if (eng >= NUM_ENGINE) begin
          eng = eng - NUM_ENGINE;
        end
        if (pops < int'(fifo_count) && !full_in[EW'(eng)]) begin
          grant_next[EW'(eng)]  = 1'b1;
          clause_next[EW'(eng)] = head_data[EW'(pops)];
          pops                  = pops + 1;
          rr_next               = (eng == NUM_ENGINE - 1) ? '0 : EW'(eng + 1);
        end
      end
    end
    pop_cnt = FCW'(pops);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      grant_out  <= '0;
      clause_out <= '0;
      rr_ptr     <= '0;
    end else begin
      grant_out  <= grant_next;
      clause_out <= clause_next;
      rr_ptr     <= rr_next;
    end
  end

  assign fifo_count_out = fifo_count;
  assign empty_out      = (fifo_count == '0);

`ifdef CLA_DISPATCH_STATS_EN
  // Counts advance on the same edge that registers the grant; flush does
  // not clear them and they hold at all-ones.
  always_ff @(posedge clock) begin
    if (reset) begin
      grant_cnt_out <= '0;
    end else begin
      for (int i = 0; i < NUM_ENGINE; i++) begin
        if (grant_next[i] && grant_cnt_out[i] != 32'hFFFF_FFFF) begin
          grant_cnt_out[i] <= grant_cnt_out[i] + 32'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_clause_dispatcher.sv
// tb_clause_dispatcher: directed self-checking bench for clause_dispatcher
// at default parameters (4 engines, IN_WIDTH 4, FIFO_DEPTH 16). The stats
// section is compiled only when CLA_DISPATCH_STATS_EN is defined.
module tb_clause_dispatcher;
  import clause_pkg::*;

  localparam int NE = 4;
  localparam int IW = 4;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   start_in;
  logic                   flush_in;
  logic [IW-1:0][CLA_W-1:0] clause_in;
  logic [2:0]             clause_cnt_in;
  logic [NE-1:0]          full_in;
  logic [2:0]             clause_accept_out;
  logic [NE-1:0][CLA_W-1:0] clause_out;
  logic [NE-1:0]          grant_out;
  logic [4:0]             fifo_count_out;
  logic                   empty_out;
`ifdef CLA_DISPATCH_STATS_EN
  logic [NE-1:0][31:0]    grant_cnt_out;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  clause_dispatcher dut (
    .clock             (clock),
    .reset             (reset),
    .start_in          (start_in),
    .flush_in          (flush_in),
    .clause_in         (clause_in),
    .clause_cnt_in     (clause_cnt_in),
    .full_in           (full_in),
    .clause_accept_out (clause_accept_out),
    .clause_out        (clause_out),
    .grant_out         (grant_out),
    .fifo_count_out    (fifo_count_out),
    .empty_out         (empty_out)
`ifdef CLA_DISPATCH_STATS_EN
    ,
    .grant_cnt_out     (grant_cnt_out)
`endif
  );

  function automatic clause_t mk(input int k);
    logic [15:0] v;
    v = 16'(k);
    return {1'b1, v, ~v};
  endfunction

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Offer n clauses mk(base..), check the combinational accept, clock once.
  task automatic apply_stimulus(input int n, input int base, input int exp_accept,
                                input string tag);
    clause_in = '0;
    for (int i = 0; i < IW; i++) begin
      if (i < n) clause_in[i] = mk(base + i);
    end
    clause_cnt_in = 3'(n);
    #1;
    check_output(tag, 64'(clause_accept_out), 64'(exp_accept));
    tick();
    clause_cnt_in = '0;
  endtask

  task automatic dispatch_once();
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
  endtask

  task automatic check_clause(input string tag, input int eng, input clause_t expected);
    check_output(tag, 64'(clause_out[eng]), 64'(expected));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; start_in = 1'b0; flush_in = 1'b0;
    clause_in = '0; clause_cnt_in = '0; full_in = '0;
    tick(); tick();

    // Reset state
    check_output("rst_grant", 64'(grant_out), 64'h0);
    for (int i = 0; i < NE; i++) check_clause("rst_clause", i, '0);
    check_output("rst_count", 64'(fifo_count_out), 64'd0);
    check_output("rst_empty", 64'(empty_out), 64'd1);
    check_output("rst_rr", 64'(dut.rr_ptr), 64'd0);
    clause_in[0] = mk(999); clause_cnt_in = 3'd4;
    #1;
    check_output("rst_accept", 64'(clause_accept_out), 64'd0);
    clause_cnt_in = '0;
    reset = 1'b0;
    tick();

    // Basic fill/dispatch: A..D in, all four engines served two edges later
    start_in = 1'b1;
    apply_stimulus(4, 1, 4, "basic_accept");
    check_output("basic_count", 64'(fifo_count_out), 64'd4);
    check_output("basic_latency", 64'(grant_out), 64'h0);
    tick();
    start_in = 1'b0;
    check_output("basic_grant", 64'(grant_out), 64'hF);
    for (int i = 0; i < NE; i++) check_clause("basic_clause", i, mk(1 + i));
    check_output("basic_rr", 64'(dut.rr_ptr), 64'd0);
    check_output("basic_drained", 64'(fifo_count_out), 64'd0);
    tick();
    check_output("grant_one_cycle", 64'(grant_out), 64'h0);

    // Backpressure skip: engine 1 full
    apply_stimulus(3, 10, 3, "skip_accept");
    full_in = 4'b0010;
    dispatch_once();
    check_output("skip_grant", 64'(grant_out), 64'b1101);
    check_clause("skip_e0", 0, mk(10));
    check_clause("skip_e2", 2, mk(11));
    check_clause("skip_e3", 3, mk(12));
    check_output("skip_rr", 64'(dut.rr_ptr), 64'd0);
    full_in = '0;

    // Partial and wrap: move rr to 3, then two clauses land on 3 and 0
    apply_stimulus(3, 20, 3, "wrap_pre_accept");
    dispatch_once();
    check_output("wrap_pre_grant", 64'(grant_out), 64'b0111);
    check_output("wrap_pre_rr", 64'(dut.rr_ptr), 64'd3);
    apply_stimulus(2, 30, 2, "wrap_accept");
    dispatch_once();
    check_output("wrap_grant", 64'(grant_out), 64'b1001);
    check_clause("wrap_e3", 3, mk(30));
    check_clause("wrap_e0", 0, mk(31));
    check_output("wrap_rr", 64'(dut.rr_ptr), 64'd1);

    // FIFO full with start low; first offer of 7 is clamped to 4
    apply_stimulus(7, 100, 4, "clamp_accept");
    apply_stimulus(4, 104, 4, "fill_accept2");
    apply_stimulus(4, 108, 4, "fill_accept3");
    apply_stimulus(4, 112, 4, "fill_accept4");
    apply_stimulus(4, 116, 0, "full_accept");
    check_output("full_count", 64'(fifo_count_out), 64'd16);
    check_output("full_empty", 64'(empty_out), 64'd0);

    // Drain to 10 entries, rotation starting at engine 1
    dispatch_once();
    check_output("drain1_grant", 64'(grant_out), 64'hF);
    check_clause("drain1_e1", 1, mk(100));
    check_clause("drain1_e2", 2, mk(101));
    check_clause("drain1_e3", 3, mk(102));
    check_clause("drain1_e0", 0, mk(103));
    check_output("drain1_rr", 64'(dut.rr_ptr), 64'd1);
    check_output("drain1_count", 64'(fifo_count_out), 64'd12);
    full_in = 4'b1100;
    dispatch_once();
    check_output("drain2_grant", 64'(grant_out), 64'b0011);
    check_clause("drain2_e1", 1, mk(104));
    check_clause("drain2_e0", 0, mk(105));
    check_output("drain2_count", 64'(fifo_count_out), 64'd10);
    full_in = '0;

    // Flush mid-stream with an offer and start high
    flush_in = 1'b1; start_in = 1'b1;
    for (int i = 0; i < IW; i++) clause_in[i] = mk(50 + i);
    clause_cnt_in = 3'd4;
    #1;
    check_output("flush_accept", 64'(clause_accept_out), 64'd0);
    tick();
    check_output("flush_count", 64'(fifo_count_out), 64'd0);
    check_output("flush_empty", 64'(empty_out), 64'd1);
    check_output("flush_grant", 64'(grant_out), 64'h0);
    check_output("flush_rr", 64'(dut.rr_ptr), 64'd1);
    flush_in = 1'b0; start_in = 1'b0; clause_cnt_in = '0;

    // Restart after flush
    apply_stimulus(1, 200, 1, "restart_accept");
    dispatch_once();
    check_output("restart_grant", 64'(grant_out), 64'b0010);
    check_clause("restart_e1", 1, mk(200));
    check_output("restart_rr", 64'(dut.rr_ptr), 64'd2);

    // Acceptance limited by remaining space (15 buffered -> 1 accepted)
    apply_stimulus(4, 300, 4, "part_accept1");
    apply_stimulus(4, 304, 4, "part_accept2");
    apply_stimulus(4, 308, 4, "part_accept3");
    apply_stimulus(3, 312, 3, "part_accept4");
    apply_stimulus(4, 315, 1, "partial_accept");
    check_output("partial_count", 64'(fifo_count_out), 64'd16);

    // Reset mid-operation
    start_in = 1'b1; reset = 1'b1;
    tick();
    check_output("midrst_count", 64'(fifo_count_out), 64'd0);
    check_output("midrst_empty", 64'(empty_out), 64'd1);
    check_output("midrst_grant", 64'(grant_out), 64'h0);
    check_output("midrst_rr", 64'(dut.rr_ptr), 64'd0);
    reset = 1'b0; start_in = 1'b0;
    tick();

`ifdef CLA_DISPATCH_STATS_EN
    for (int i = 0; i < NE; i++)
      check_output("stats_reset", 64'(grant_cnt_out[i]), 64'd0);
    apply_stimulus(4, 400, 4, "stats_acc1");
    dispatch_once();
    apply_stimulus(4, 410, 4, "stats_acc2");
    dispatch_once();
    apply_stimulus(1, 420, 1, "stats_acc3");
    dispatch_once();
    check_output("stats_e0", 64'(grant_cnt_out[0]), 64'd3);
    check_output("stats_e1", 64'(grant_cnt_out[1]), 64'd2);
    check_output("stats_e2", 64'(grant_cnt_out[2]), 64'd2);
    check_output("stats_e3", 64'(grant_cnt_out[3]), 64'd2);
    apply_stimulus(2, 430, 2, "stats_acc4");
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    check_output("stats_flush_e0", 64'(grant_cnt_out[0]), 64'd3);
    check_output("stats_flush_e3", 64'(grant_cnt_out[3]), 64'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < NE; i++)
      check_output("stats_clear", 64'(grant_cnt_out[i]), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
